// File: rtl/hurricane_ctrl.sv
// Hurricane (mode 3) run-permission controller: allows one timed hurricane run
// per power-on session and reports whether to exit to mode 2 or to standby.
module hurricane_ctrl #(
   parameter int unsigned CYCLES_PER_SEC = 100_000_000,
   parameter int unsigned HURRICANE_SEC  = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       machine_state,
   input  logic [2:0] mode_state,
   input  logic       menu_btn,
   output logic       hurricane_mode_enabled,
   output logic       return_state,
   output logic       countdown_active,
   output logic [7:0] countdown_sec
);

   localparam int TICK_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CYCLES_PER_SEC - 1);
   localparam logic [7:0]        RUN_SEC   = 8'(HURRICANE_SEC);
   localparam logic [2:0]        MODE_HURR = 3'b011;

   typedef enum logic [1:0] {S_OFF, S_READY, S_RUN, S_SPENT} state_t;

   state_t            state_reg;
   logic [TICK_W-1:0] tick_reg;
   logic              used_reg;
   logic              mode_prev_reg;
   logic              menu_prev_reg;

   logic mode_hurr;
   logic mode_entry;
   logic menu_rise;

   assign mode_hurr  = (mode_state == MODE_HURR);
   assign mode_entry = mode_hurr & ~mode_prev_reg;
   assign menu_rise  = menu_btn & ~menu_prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg              <= S_OFF;
         tick_reg               <= '0;
         used_reg               <= 1'b0;
         mode_prev_reg          <= 1'b0;
         menu_prev_reg          <= 1'b0;
         hurricane_mode_enabled <= 1'b0;
         return_state           <= 1'b0;
         countdown_active       <= 1'b0;
         countdown_sec          <= 8'd0;
      end else begin
         mode_prev_reg <= mode_hurr;
         menu_prev_reg <= menu_btn;
         if (!machine_state) begin
            state_reg              <= S_OFF;
            tick_reg               <= '0;
            used_reg               <= 1'b0;
            hurricane_mode_enabled <= 1'b0;
            return_state           <= 1'b0;
            countdown_active       <= 1'b0;
            countdown_sec          <= 8'd0;
         end else begin
            case (state_reg)
               S_OFF: begin
                  state_reg              <= S_READY;
                  hurricane_mode_enabled <= 1'b1;
               end
               S_READY: begin
                  // Only a fresh transition into mode 3 starts a run.
                  if (mode_entry && !used_reg) begin
                     state_reg        <= S_RUN;
                     used_reg         <= 1'b1;
                     tick_reg         <= '0;
                     countdown_sec    <= RUN_SEC;
                     countdown_active <= 1'b1;
                     return_state     <= 1'b0;
                  end
               end
               S_RUN: begin
                  if (menu_rise)
                     return_state <= 1'b1;
                  if (!mode_hurr) begin
                     state_reg              <= S_SPENT;
                     tick_reg               <= '0;
                     hurricane_mode_enabled <= 1'b0;
                     countdown_active       <= 1'b0;
                     countdown_sec          <= 8'd0;
                  end else if (tick_reg == TICK_LAST) begin
                     tick_reg      <= '0;
                     countdown_sec <= countdown_sec - 8'd1;
                     // Last second elapsed: run is over, force the exit.
                     if (countdown_sec == 8'd1) begin
                        state_reg              <= S_SPENT;
                        hurricane_mode_enabled <= 1'b0;
                        countdown_active       <= 1'b0;
                     end
                  end else begin
                     tick_reg <= tick_reg + 1'b1;
                  end
               end
               S_SPENT: begin
                  hurricane_mode_enabled <= 1'b0;
                  if (!mode_hurr)
                     return_state <= 1'b0;
               end
               default: state_reg <= S_OFF;
            endcase
         end
      end
   end

endmodule

// File: doc/hurricane_ctrl.md
HURRICANE_CTRL -- requirements
Module: hurricane_ctrl

Interface
REQ-001 Parameter CYCLES_PER_SEC, default 100_000_000, clk cycles per one-second tick.
REQ-002 Parameter HURRICANE_SEC, default 60, mode-3 run length in seconds (1..255).
REQ-003 Port clk  input  1  system clock; single clock domain, all state updates on posedge clk.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port machine_state  input  1  1 = appliance powered on.
REQ-006 Port mode_state  input  3  current mode from the mode FSM; 3'b011 = hurricane.
REQ-007 Port menu_btn  input  1  debounced, level-high menu button.
REQ-008 Port hurricane_mode_enabled  output  1  1 = mode 3 may be entered or held; 0 forces exit.
REQ-009 Port return_state  output  1  valid when enabled falls; 1 = exit to mode 2, 0 = exit to standby.
REQ-010 Port countdown_active  output  1  1 while the mode-3 countdown runs.
REQ-011 Port countdown_sec  output  8  remaining whole seconds, for display.

Function
REQ-012 States SHALL be OFF, READY, RUN, SPENT; all outputs SHALL be registered.
REQ-013 In any state, machine_state=0 SHALL, on the next edge, go OFF with all outputs 0, tick counter 0, and the used flag cleared.
REQ-014 OFF -> READY SHALL occur on the first edge with machine_state=1; READY drives enabled=1.
REQ-015 READY -> RUN SHALL occur on the first edge where mode_state==3'b011 and was not 3'b011 on the previous edge. On that edge: countdown_sec<=HURRICANE_SEC, tick counter<=0, countdown_active<=1, return_state<=0.
REQ-016 In RUN, the tick counter SHALL increment every cycle.
REQ-017 When the tick counter equals CYCLES_PER_SEC-1, it SHALL wrap to 0 and countdown_sec SHALL decrement by 1 on that same edge.
REQ-018 A decrement that takes countdown_sec from 1 to 0 SHALL, on the same edge, set enabled<=0 and countdown_active<=0, and move to SPENT.
REQ-019 A rising edge of menu_btn (registered edge detect) in RUN SHALL set return_state<=1. The setting is sticky and further edges have no effect.
REQ-020 A menu rising edge on the same edge as expiry SHALL still set return_state=1.
REQ-021 In RUN, mode_state leaving 3'b011 before expiry SHALL move to SPENT with enabled=0, countdown_active=0, countdown_sec=0, and return_state held.
REQ-022 In SPENT, enabled SHALL stay 0 until the machine is powered off: one hurricane run per power-on session.
REQ-023 In SPENT, return_state SHALL hold until the first edge with mode_state!=3'b011, then clear to 0.
REQ-024 Entry into mode 3 observed in SPENT or OFF SHALL be ignored and produce no countdown.
REQ-025 countdown_sec SHALL never underflow; it holds 0 outside RUN.

Reset
REQ-026 While rst=0, all outputs SHALL be 0. State SHALL be OFF, the tick counter 0, the used flag 0 and the edge-detect register 0.
REQ-027 Reset asserted mid-RUN SHALL abort the countdown immediately (asynchronous). After release the block SHALL resume from OFF as in REQ-014.

Verification (bench uses CYCLES_PER_SEC=4, HURRICANE_SEC=3)
REQ-028 Reset -> enabled, return_state, countdown_active = 0 and countdown_sec=0. Then machine_state=1 -> enabled=1 after 1 edge.
REQ-029 mode_state=011, no menu -> countdown_sec 3,2,1,0 at 4-cycle spacing. enabled and active fall on the edge countdown_sec reaches 0 (12 cycles after entry). return_state=0.
REQ-030 Same run with a menu press at cycle 5 -> return_state=1 at expiry. return_state holds while mode_state=011 and clears the cycle after mode_state=010.
REQ-031 After a completed run, mode_state to 000 then back to 011 -> enabled stays 0 and countdown_sec stays 0. Then machine_state 0->1 -> enabled=1 again.
REQ-032 Menu rising edge coincident with the final tick -> return_state=1 and enabled=0 on the same edge.
REQ-033 rst pulsed low at countdown_sec=2 -> all outputs 0 at once. After release with machine_state=1 -> enabled=1 after 1 edge, countdown_active=0.
